// File: rtl/opera_bus_pkg.sv
// Shared definitions for the 3DO CPU-side bus controller: the address map,
// the region and FSM encodings, and the fill words returned for SVF reads and timeouts.
package opera_bus_pkg;

  // Inclusive address windows of the on-chip register targets
  localparam logic [31:0] SVF_BASE    = 32'h0320_0000;
  localparam logic [31:0] SVF_LIMIT   = 32'h0320_FFFF;
  localparam logic [31:0] MADAM_BASE  = 32'h0330_0000;
  localparam logic [31:0] MADAM_LIMIT = 32'h0330_FFFF;
  localparam logic [31:0] CLIO_BASE   = 32'h0340_0000;
  localparam logic [31:0] CLIO_LIMIT  = 32'h0340_FFFF;

  // Tables indexed in the same order as the region enum (0 = SVF, 1 = MADAM, 2 = CLIO)
  localparam logic [2:0][31:0] REGION_BASE  = {CLIO_BASE,  MADAM_BASE,  SVF_BASE};
  localparam logic [2:0][31:0] REGION_LIMIT = {CLIO_LIMIT, MADAM_LIMIT, SVF_LIMIT};

  // Data returned for SVF reads, which have no real read port
  localparam logic [31:0] SVF_FILL     = 32'hBADA_CCE5;
  // Data returned when an external cycle gets no answer
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_DEAD;

  typedef enum logic [1:0] {
    REG_SVF   = 2'd0,
    REG_MADAM = 2'd1,
    REG_CLIO  = 2'd2,
    REG_EXT   = 2'd3
  } region_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STROBE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXT    = 3'd3,
    ST_ACK    = 3'd4
  } state_t;

endpackage

// File: rtl/opera_addr_decode.sv
// Combinational address decoder: maps a CPU address onto the target region.
// Anything outside the three register windows belongs to the external port.
module opera_addr_decode
  import opera_bus_pkg::*;
(
  input  logic [31:0] adr,
  output region_t     region
);

  logic [2:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hit
      assign hit[gi] = (adr >= REGION_BASE[gi]) && (adr <= REGION_LIMIT[gi]);
    end
  endgenerate

  // Windows do not overlap, so the priority order only matters for readability
  always_comb begin
    region = REG_EXT;
    if (hit[0])      region = REG_SVF;
    else if (hit[1]) region = REG_MADAM;
    else if (hit[2]) region = REG_CLIO;
  end

endmodule

// File: rtl/opera_bus_ctrl.sv
// CPU-side bus controller: decodes each Wishbone cycle, strobes the register
// target with per-target wait states, or runs an external cycle guarded by a
// timeout, then terminates the CPU cycle with a one-cycle ack.
module opera_bus_ctrl
  import opera_bus_pkg::*;
#(
  parameter int WAIT_MADAM = 1,
  parameter int WAIT_CLIO  = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  input  logic [3:0]  wb_sel,
  input  logic        wb_we,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic        wb_ack,
  output logic [31:0] wb_dat_r,
  output logic        madam_rd,
  output logic        madam_wr,
  input  logic [31:0] madam_dout,
  output logic        clio_rd,
  output logic        clio_wr,
  input  logic [31:0] clio_dout,
  output logic [31:0] tgt_adr,
  output logic [31:0] tgt_dat,
  output logic        ext_stb,
  output logic        ext_we,
  output logic [3:0]  ext_sel,
  input  logic        ext_ack,
  input  logic [31:0] ext_dat,
  output logic        bus_timeout
);

  state_t      state_reg, state_next;
  region_t     dec_region, region_reg;
  logic        we_reg;
  logic [3:0]  sel_reg;
  logic [31:0] adr_reg, dat_reg, dat_r_reg;
  logic [3:0]  wait_cnt_reg, wait_load;
  logic [7:0]  to_cnt_reg;
  logic        timeout_reg;
  logic        req, to_hit, entering_ack;

  opera_addr_decode u_decode (
    .adr    (wb_adr),
    .region (dec_region)
  );

  assign req          = wb_cyc & wb_stb;
  assign to_hit       = (to_cnt_reg == 8'(TIMEOUT));
  assign entering_ack = (state_next == ST_ACK) && (state_reg != ST_ACK);

  // Wait-state count for the latched target; SVF answers with no extra wait
  always_comb begin
    wait_load = 4'd0;
    case (region_reg)
      REG_MADAM: wait_load = 4'(WAIT_MADAM);
      REG_CLIO:  wait_load = 4'(WAIT_CLIO);
      default:   wait_load = 4'd0;
    endcase
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // FSM next state; dropping wb_cyc abandons the cycle without an ack
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (req) state_next = (dec_region == REG_EXT) ? ST_EXT : ST_STROBE;
      ST_STROBE: if (!wb_cyc)                 state_next = ST_IDLE;
                 else if (wait_load == 4'd0)  state_next = ST_ACK;
                 else                         state_next = ST_WAIT;
      ST_WAIT:   if (!wb_cyc)                 state_next = ST_IDLE;
                 else if (wait_cnt_reg <= 4'd1) state_next = ST_ACK;
      ST_EXT:    if (!wb_cyc)                 state_next = ST_IDLE;
                 else if (ext_ack || to_hit)  state_next = ST_ACK;
      ST_ACK:    state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: strobes live only in STROBE, so an aborted cycle never retracts one
  always_comb begin
    madam_rd = 1'b0;
    madam_wr = 1'b0;
    clio_rd  = 1'b0;
    clio_wr  = 1'b0;
    if (state_reg == ST_STROBE) begin
      case (region_reg)
        REG_MADAM: begin madam_rd = !we_reg; madam_wr = we_reg; end
        REG_CLIO:  begin clio_rd  = !we_reg; clio_wr  = we_reg; end
        default:   ;
      endcase
    end
    wb_ack  = (state_reg == ST_ACK);
    ext_stb = (state_reg == ST_EXT);
  end

  // Latch the request when it is accepted in IDLE
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      adr_reg    <= '0;
      dat_reg    <= '0;
      sel_reg    <= '0;
      we_reg     <= 1'b0;
      region_reg <= REG_EXT;
    end else if (state_reg == ST_IDLE && req) begin
      adr_reg    <= wb_adr;
      dat_reg    <= wb_dat_w;
      sel_reg    <= wb_sel;
      we_reg     <= wb_we;
      region_reg <= dec_region;
    end
  end

  // Wait and timeout counters; both saturate instead of wrapping
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_reg <= 4'd0;
      to_cnt_reg   <= 8'd0;
    end else begin
      case (state_reg)
        ST_IDLE:   to_cnt_reg <= 8'd0;
        ST_STROBE: wait_cnt_reg <= wait_load;
        ST_WAIT:   if (wait_cnt_reg != 4'd0) wait_cnt_reg <= wait_cnt_reg - 4'd1;
        ST_EXT:    if (to_cnt_reg != 8'hFF)  to_cnt_reg   <= to_cnt_reg + 8'd1;
        default:   ;
      endcase
    end
  end

  // Read data is captured on the edge entering ACK; writes leave it untouched
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      dat_r_reg <= '0;
    end else if (entering_ack && !we_reg) begin
      if (state_reg == ST_EXT) begin
        dat_r_reg <= ext_ack ? ext_dat : TIMEOUT_FILL;
      end else begin
        case (region_reg)
          REG_MADAM: dat_r_reg <= madam_dout;
          REG_CLIO:  dat_r_reg <= clio_dout;
          default:   dat_r_reg <= SVF_FILL;
        endcase
      end
    end
  end

  // Timeout flag lines up with the ack cycle; a late ext_ack still wins
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) timeout_reg <= 1'b0;
    else          timeout_reg <= (state_reg == ST_EXT) && entering_ack && !ext_ack;
  end

  assign wb_dat_r    = dat_r_reg;
  assign tgt_adr     = adr_reg;
  assign tgt_dat     = dat_reg;
  assign ext_we      = we_reg;
  assign ext_sel     = sel_reg;
  assign bus_timeout = timeout_reg;

endmodule
